// File: rtl/mul_seq_half.sv
// -----------------------------------------------------------------------------
// mul_seq_half
// Two-stage FP16 multiplier feeding the half-precision accumulator stage.
// Operand pairs arrive on a valid/ready stream. The product reaches x two
// cycles after the pair is accepted, together with the n (start new sum) and
// last (final element) tags. res_valid pulses RES_DLY cycles after last, which
// is when the accumulator's registered sum for that vector is final.
//
// Ports:
//   clock, resetn      rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (no downstream backpressure)
//   a, b               FP16 operands
//   vec_len            elements per vector, sampled on a vector's first element
//   clear              synchronous abort of the vector being counted
//   x                  FP16 product (0x0000 in bubble cycles)
//   n, last            first / final product of a vector
//   res_valid          accumulator sum for the finished vector is valid
//   busy               vector partially accepted or work still in flight
// -----------------------------------------------------------------------------
module mul_seq_half #(
  parameter int LEN_W   = 8,
  parameter int RES_DLY = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             clear,
  output logic [15:0]      x,
  output logic             n,
  output logic             last,
  output logic             res_valid,
  output logic             busy
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

  // IEEE binary16 multiply, round to nearest even. Subnormals in and out are
  // flushed to signed zero; NaN and inf*0 produce the canonical quiet NaN.
  function automatic logic [15:0] fp16_mul(input logic [15:0] op_a, input logic [15:0] op_b);
    logic        sign;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0] prod;
    logic [10:0] mant;
    logic        guard, sticky, rnd_up;
    logic [11:0] mant_r;
    logic [7:0]  e_sum;
    logic [4:0]  e_res;
    logic [15:0] res;
    sign   = op_a[15] ^ op_b[15];
    a_nan  = (op_a[14:10] == 5'h1F) && (op_a[9:0] != 10'h000);
    b_nan  = (op_b[14:10] == 5'h1F) && (op_b[9:0] != 10'h000);
    a_inf  = (op_a[14:10] == 5'h1F) && (op_a[9:0] == 10'h000);
    b_inf  = (op_b[14:10] == 5'h1F) && (op_b[9:0] == 10'h000);
    a_zero = (op_a[14:10] == 5'h00);
    b_zero = (op_b[14:10] == 5'h00);
    prod   = {11'd0, 1'b1, op_a[9:0]} * {11'd0, 1'b1, op_b[9:0]};
    // The product of two [1,2) significands lies in [1,4): bit 21 set means
    // one extra bit of normalisation shift and one more exponent step.
    if (prod[21]) begin
      mant   = prod[21:11];
      guard  = prod[10];
      sticky = |prod[9:0];
    end else begin
      mant   = prod[20:10];
      guard  = prod[9];
      sticky = |prod[8:0];
    end
    rnd_up = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {11'd0, rnd_up};
    // e_sum carries the double bias; valid biased results are e_sum-15 in 1..30.
    e_sum  = {3'b000, op_a[14:10]} + {3'b000, op_b[14:10]}
           + {7'd0, prod[21]} + {7'd0, mant_r[11]};
    e_res  = e_sum[4:0] - 5'd15;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res = 16'h7E00;
    end else if (a_inf || b_inf) begin
      res = {sign, 5'h1F, 10'h000};
    end else if (a_zero || b_zero) begin
      res = {sign, 15'h0000};
    end else if (e_sum >= 8'd46) begin
      res = {sign, 5'h1F, 10'h000};
    end else if (e_sum <= 8'd15) begin
      res = {sign, 15'h0000};
    end else begin
      // A rounding carry leaves mant_r = 0x800, i.e. a zero fraction.
      res = {sign, e_res, (mant_r[11] ? mant_r[10:1] : mant_r[9:0])};
    end
    return res;
  endfunction

  logic             rdy_q;
  logic [0:0]       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_eff;
  logic             accept;
  logic             tag_n, tag_last;

  logic             s1_vld_q, s1_vld_d;
  logic [15:0]      s1_a_q, s1_a_d;
  logic [15:0]      s1_b_q, s1_b_d;
  logic             s1_n_q, s1_n_d;
  logic             s1_last_q, s1_last_d;

  logic             s2_vld_q, s2_vld_d;
  logic [15:0]      x_q, x_d;
  logic             n_q, n_d;
  logic             last_q, last_d;

  logic [RES_DLY-1:0] res_sr_q, res_sr_d;

  assign in_ready  = rdy_q & ~clear;
  assign accept    = in_valid & in_ready;
  assign len_eff   = (vec_len == LEN_ZERO) ? LEN_ONE : vec_len;
  assign x         = x_q;
  assign n         = n_q;
  assign last      = last_q;
  assign res_valid = res_sr_q[RES_DLY-1];
  assign busy      = (state_q == ST_RUN) | s1_vld_q | s2_vld_q | (|res_sr_q);

  // Element counter: tags the first and final accept of each vector.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    tag_n    = 1'b0;
    tag_last = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      rem_d   = LEN_ZERO;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          tag_n = 1'b1;
          if (len_eff == LEN_ONE) begin
            tag_last = 1'b1;
            state_d  = ST_IDLE;
            rem_d    = LEN_ZERO;
          end else begin
            state_d  = ST_RUN;
            rem_d    = len_eff - LEN_ONE;
          end
        end
        ST_RUN: begin
          rem_d = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            tag_last = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rem_d   = LEN_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
      rem_d   = rem_q;
    end
  end

  // Stage 1: capture operands and tags; empty slots carry zeros.
  always_comb begin
    if (accept) begin
      s1_vld_d  = 1'b1;
      s1_a_d    = a;
      s1_b_d    = b;
      s1_n_d    = tag_n;
      s1_last_d = tag_last;
    end else begin
      s1_vld_d  = 1'b0;
      s1_a_d    = 16'h0000;
      s1_b_d    = 16'h0000;
      s1_n_d    = 1'b0;
      s1_last_d = 1'b0;
    end
  end

  // Stage 2: multiply; bubbles present x=0 so the accumulator adds nothing.
  always_comb begin
    if (s1_vld_q) begin
      s2_vld_d = 1'b1;
      x_d      = fp16_mul(s1_a_q, s1_b_q);
      n_d      = s1_n_q;
      last_d   = s1_last_q;
    end else begin
      s2_vld_d = 1'b0;
      x_d      = 16'h0000;
      n_d      = 1'b0;
      last_d   = 1'b0;
    end
  end

  // res_valid delay line, fed by last as it leaves stage 2.
  always_comb begin
    res_sr_d    = res_sr_q;
    res_sr_d[0] = last_q;
    for (int i = 1; i < RES_DLY; i++) begin
      res_sr_d[i] = res_sr_q[i-1];
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdy_q     <= 1'b0;
      state_q   <= ST_IDLE;
      rem_q     <= LEN_ZERO;
      s1_vld_q  <= 1'b0;
      s1_a_q    <= 16'h0000;
      s1_b_q    <= 16'h0000;
      s1_n_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      x_q       <= 16'h0000;
      n_q       <= 1'b0;
      last_q    <= 1'b0;
      res_sr_q  <= {RES_DLY{1'b0}};
    end else begin
      rdy_q     <= 1'b1;
      state_q   <= state_d;
      rem_q     <= rem_d;
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_n_q    <= s1_n_d;
      s1_last_q <= s1_last_d;
      s2_vld_q  <= s2_vld_d;
      x_q       <= x_d;
      n_q       <= n_d;
      last_q    <= last_d;
      res_sr_q  <= res_sr_d;
    end
  end

endmodule
